// File: rtl/i2c_target.sv
// I2C target with an EEPROM-style register file: a write sets the register
// pointer and stores data bytes, a read returns bytes starting at the pointer.
// SCL/SDA are oversampled on clk_25MHz; SDA is driven open-drain (low only).
module i2c_target #(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned DEPTH    = 256,
    parameter logic [7:0]  INIT_VAL = 8'h00
) (
    input  logic       clk_25MHz,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]  PTR_MASK = 8'(DEPTH - 1);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    state_t     state, state_n;
    logic [7:0] ptr, ptr_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] tx, tx_n;
    logic       sda_oe_n, busy_n, wr_strobe_n;
    logic [7:0] wr_addr_n, wr_data_n;
    logic       mem_we;
    logic [7:0] mem [DEPTH];
    logic [7:0] mem_rd;

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;
    logic scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_c, stop_c;

    // Two-stage synchronizers plus history flops; reset to an idle (high) bus
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl_i;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    // Single-cycle edge events and bus conditions
    always_comb begin
        scl_rise = scl_s2 & ~scl_d;
        scl_fall = ~scl_s2 & scl_d;
        sda_rise = sda_s2 & ~sda_d;
        sda_fall = ~sda_s2 & sda_d;
        start_c  = sda_fall & scl_s2;
        stop_c   = sda_rise & scl_s2;
    end

    assign mem_rd = mem[ptr[AW-1:0]];

    // Register file; written only on a completed data byte
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= INIT_VAL;
            end
        end else if (mem_we) begin
            mem[ptr[AW-1:0]] <= shreg;
        end
    end

    // State and output registers
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= 8'h00;
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            tx        <= 8'h00;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            tx        <= tx_n;
            sda_oe    <= sda_oe_n;
            busy      <= busy_n;
            wr_strobe <= wr_strobe_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
        end
    end

    // Next-state and output decode; START/STOP override everything else
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        tx_n        = tx;
        sda_oe_n    = sda_oe;
        busy_n      = busy;
        wr_strobe_n = 1'b0;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        mem_we      = 1'b0;

        case (state)
            IDLE: begin
                sda_oe_n = 1'b0;
            end
            ADDR, REG, WDATA: begin
                if (scl_rise) begin
                    shreg_n   = {shreg[6:0], sda_s2};
                    bit_cnt_n = bit_cnt + 4'd1;
                end else if (scl_fall && bit_cnt == 4'd8) begin
                    if (state == ADDR) begin
                        if (shreg[7:1] == DEV_ADDR) begin
                            sda_oe_n = 1'b1;
                            busy_n   = 1'b1;
                            state_n  = ADDR_ACK;
                        end else begin
                            state_n  = IGNORE;
                        end
                    end else if (state == REG) begin
                        ptr_n    = shreg & PTR_MASK;
                        sda_oe_n = 1'b1;
                        state_n  = REG_ACK;
                    end else begin
                        mem_we      = 1'b1;
                        wr_strobe_n = 1'b1;
                        wr_addr_n   = ptr;
                        wr_data_n   = shreg;
                        ptr_n       = (ptr + 8'd1) & PTR_MASK;
                        sda_oe_n    = 1'b1;
                        state_n     = WDATA_ACK;
                    end
                end
            end
            ADDR_ACK: begin
                if (scl_fall) begin
                    bit_cnt_n = 4'd0;
                    if (shreg[0]) begin
                        tx_n     = mem_rd;
                        sda_oe_n = ~mem_rd[7];
                        state_n  = RDATA;
                    end else begin
                        sda_oe_n = 1'b0;
                        state_n  = REG;
                    end
                end
            end
            REG_ACK, WDATA_ACK: begin
                if (scl_fall) begin
                    sda_oe_n  = 1'b0;
                    bit_cnt_n = 4'd0;
                    state_n   = WDATA;
                end
            end
            RDATA: begin
                if (scl_rise) begin
                    bit_cnt_n = bit_cnt + 4'd1;
                end else if (scl_fall) begin
                    if (bit_cnt == 4'd8) begin
                        sda_oe_n = 1'b0;
                        state_n  = RDATA_ACK;
                    end else begin
                        tx_n     = {tx[6:0], 1'b0};
                        sda_oe_n = ~tx[6];
                    end
                end
            end
            RDATA_ACK: begin
                if (scl_rise) begin
                    ptr_n = (ptr + 8'd1) & PTR_MASK;
                    if (sda_s2) begin
                        busy_n  = 1'b0;
                        state_n = IGNORE;
                    end
                end else if (scl_fall) begin
                    bit_cnt_n = 4'd0;
                    tx_n      = mem_rd;
                    sda_oe_n  = ~mem_rd[7];
                    state_n   = RDATA;
                end
            end
            IGNORE: begin
                sda_oe_n = 1'b0;
            end
            default: begin
                sda_oe_n = 1'b0;
                state_n  = IDLE;
            end
        endcase

        if (stop_c) begin
            state_n     = IDLE;
            sda_oe_n    = 1'b0;
            busy_n      = 1'b0;
            bit_cnt_n   = 4'd0;
            mem_we      = 1'b0;
            wr_strobe_n = 1'b0;
        end
        if (start_c) begin
            state_n     = ADDR;
            sda_oe_n    = 1'b0;
            busy_n      = 1'b0;
            bit_cnt_n   = 4'd0;
            mem_we      = 1'b0;
            wr_strobe_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged bus master with an open-drain
// SDA model drives write, read, wrap, mismatch, abort and reset sequences.
module tb_i2c_target;

    localparam int Q = 200;  // quarter SCL bit time = 5 clk periods

    logic       clk_25MHz;
    logic       reset;
    logic       scl;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int errors = 0;
    int checks = 0;

    int         strobe_cnt = 0;
    logic [7:0] last_addr  = 8'h00;
    logic [7:0] last_data  = 8'h00;
    logic       oe_seen    = 1'b0;
    logic       busy_seen  = 1'b0;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target dut (
        .clk_25MHz (clk_25MHz),
        .reset     (reset),
        .scl_i     (scl),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    initial clk_25MHz = 1'b0;
    always #20 clk_25MHz = ~clk_25MHz;

    // Observe strobes and any SDA drive / busy activity
    always @(negedge clk_25MHz) begin
        if (wr_strobe) begin
            strobe_cnt = strobe_cnt + 1;
            last_addr  = wr_addr;
            last_data  = wr_data;
        end
        if (sda_oe) oe_seen = 1'b1;
        if (busy)   busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        sda_m = b;
        #Q scl = 1'b1;
        #Q s = sda_bus;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        #Q scl = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        #Q scl = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
        repeat (4) @(posedge clk_25MHz);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d, output logic slot);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, s);
            d = {d[6:0], s};
        end
        bit_xfer(mack, slot);
    endtask

    initial begin
        logic       ack;
        logic       slot;
        logic [7:0] d;
        int         base;

        reset = 1'b1;
        scl   = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(posedge clk_25MHz);
        @(negedge clk_25MHz);
        check("rst_sda_oe", 32'(sda_oe), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'h0);
        check("rst_wr_addr", 32'(wr_addr), 32'h0);
        check("rst_wr_data", 32'(wr_data), 32'h0);
        reset = 1'b0;
        repeat (4) @(posedge clk_25MHz);

        // Basic write: reg 0x92 <= 0xAC
        i2c_start();
        wr_byte(8'hA0, ack); check("wr_addr_ack", 32'(ack), 32'h0);
        @(negedge clk_25MHz); check("wr_busy", 32'(busy), 32'h1);
        wr_byte(8'h92, ack); check("wr_reg_ack", 32'(ack), 32'h0);
        wr_byte(8'hAC, ack); check("wr_data_ack", 32'(ack), 32'h0);
        i2c_stop();
        check("wr_strobe_cnt", 32'(strobe_cnt), 32'd1);
        check("wr_strobe_addr", 32'(last_addr), 32'h92);
        check("wr_strobe_data", 32'(last_data), 32'hAC);
        check("wr_busy_after_stop", 32'(busy), 32'h0);
        check("wr_ptr", 32'(dut.ptr), 32'h93);

        // Random read of reg 0x92 via repeated START
        i2c_start();
        wr_byte(8'hA0, ack);
        wr_byte(8'h92, ack);
        i2c_start();
        wr_byte(8'hA1, ack); check("rd_addr_ack", 32'(ack), 32'h0);
        rd_byte(1'b1, d, slot);
        check("rd_data", 32'(d), 32'hAC);
        check("rd_nack_slot_released", 32'(slot), 32'h1);
        i2c_stop();
        check("rd_ptr", 32'(dut.ptr), 32'h93);
        check("rd_busy", 32'(busy), 32'h0);

        // Sequential write and read across the pointer wrap
        base = strobe_cnt;
        i2c_start();
        wr_byte(8'hA0, ack);
        wr_byte(8'hFF, ack);
        wr_byte(8'h11, ack); check("wrap_wr1_ack", 32'(ack), 32'h0);
        wr_byte(8'h22, ack); check("wrap_wr2_ack", 32'(ack), 32'h0);
        i2c_stop();
        check("wrap_strobe_cnt", 32'(strobe_cnt - base), 32'd2);
        check("wrap_last_addr", 32'(last_addr), 32'h00);
        check("wrap_last_data", 32'(last_data), 32'h22);
        i2c_start();
        wr_byte(8'hA0, ack);
        wr_byte(8'hFF, ack);
        i2c_start();
        wr_byte(8'hA1, ack);
        rd_byte(1'b0, d, slot); check("wrap_rd1", 32'(d), 32'h11);
        rd_byte(1'b1, d, slot); check("wrap_rd2", 32'(d), 32'h22);
        i2c_stop();
        check("wrap_ptr", 32'(dut.ptr), 32'h01);

        // Address mismatch: 0x51 is not ours
        base = strobe_cnt;
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        i2c_start();
        wr_byte(8'hA2, ack); check("mis_nack", 32'(ack), 32'h1);
        i2c_stop();
        check("mis_oe_seen", 32'(oe_seen), 32'h0);
        check("mis_busy_seen", 32'(busy_seen), 32'h0);
        check("mis_strobe", 32'(strobe_cnt - base), 32'd0);

        // STOP after 5 data bits discards the partial byte
        base = strobe_cnt;
        i2c_start();
        wr_byte(8'hA0, ack);
        wr_byte(8'h10, ack);
        for (int i = 0; i < 5; i++) bit_xfer(1'b1, slot);
        i2c_stop();
        check("abort_strobe", 32'(strobe_cnt - base), 32'd0);
        check("abort_mem", 32'(dut.mem[8'h10]), 32'h00);
        check("abort_sda_oe", 32'(sda_oe), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        i2c_start();
        wr_byte(8'hA0, ack);
        wr_byte(8'h10, ack);
        wr_byte(8'h5A, ack); check("abort_retry_ack", 32'(ack), 32'h0);
        i2c_stop();
        check("abort_retry_strobe", 32'(strobe_cnt - base), 32'd1);
        check("abort_retry_addr", 32'(last_addr), 32'h10);
        check("abort_retry_data", 32'(last_data), 32'h5A);

        // Reset while the target drives a 0 data bit (0x3C, MSB = 0)
        i2c_start();
        wr_byte(8'hA0, ack);
        wr_byte(8'h20, ack);
        wr_byte(8'h3C, ack);
        i2c_stop();
        i2c_start();
        wr_byte(8'hA0, ack);
        wr_byte(8'h20, ack);
        i2c_start();
        wr_byte(8'hA1, ack);
        @(negedge clk_25MHz);
        check("rstrd_driving", 32'(sda_oe), 32'h1);
        reset = 1'b1;
        @(posedge clk_25MHz);
        @(negedge clk_25MHz);
        check("rstrd_sda_oe", 32'(sda_oe), 32'h0);
        check("rstrd_ptr", 32'(dut.ptr), 32'h00);
        check("rstrd_mem20", 32'(dut.mem[8'h20]), 32'h00);
        check("rstrd_mem92", 32'(dut.mem[8'h92]), 32'h00);
        reset = 1'b0;
        base = strobe_cnt;
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 9; i++) bit_xfer(1'b1, slot);
        check("rstrd_ignore_oe", 32'(oe_seen), 32'h0);
        check("rstrd_ignore_busy", 32'(busy_seen), 32'h0);
        i2c_stop();
        i2c_start();
        wr_byte(8'hA0, ack); check("post_rst_ack", 32'(ack), 32'h0);
        wr_byte(8'h05, ack);
        wr_byte(8'h77, ack);
        i2c_stop();
        check("post_rst_strobe", 32'(strobe_cnt - base), 32'd1);
        check("post_rst_addr", 32'(last_addr), 32'h05);
        check("post_rst_data", 32'(last_data), 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) that answers the existing bit-banged I2C initiator. It is an EEPROM-style register file: a write sets an 8-bit register pointer and then stores data bytes; a read returns bytes starting at the pointer.
- SCL and SDA are oversampled on the 25 MHz system clock. The block never drives SCL and drives SDA open-drain, low only.
- A fabric-side strobe reports every byte written by the bus.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address matched after START.
- DEPTH, 256, register-file depth in bytes (power of 2, ≤256). Pointer wraps modulo DEPTH.
- INIT_VAL, 8'h00, reset value of every register byte.

Ports:
- clk_25MHz  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- scl_i  input  1  bus SCL (asynchronous to clk_25MHz).
- sda_i  input  1  bus SDA (asynchronous to clk_25MHz).
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- wr_strobe  output  1  one-cycle pulse when a data byte is stored.
- wr_addr  output  8  register index of the stored byte; valid with wr_strobe.
- wr_data  output  8  stored byte; valid with wr_strobe.
- busy  output  1  high from addressed START (address match) to STOP.

Behaviour:
- Input conditioning:
  - scl_i and sda_i each pass through a 2-FF synchronizer plus a history FF.
  - Edge events (scl_rise, scl_fall, sda_fall, sda_rise) are single-cycle and appear 3 clk after the pin change.
- Bus conditions:
  - START = sda_fall while synced SCL = 1.
  - STOP = sda_rise while synced SCL = 1.
  - Both are recognised in every state, including mid-byte. START wins over any data action in the same cycle.
- Bit sampling and driving:
  - Data is sampled on scl_rise, MSB first.
  - sda_oe changes only on scl_fall, never while SCL is high.
- bit_cnt (4 bits): cleared on START and after each ACK slot; it counts 0..8.
- States:
  - IDLE: sda_oe=0. START -> ADDR.
  - ADDR: shift 8 bits. On the 8th scl_fall:
    - If [7:1] == DEV_ADDR, set sda_oe=1 -> ADDR_ACK.
    - Otherwise -> IGNORE.
  - ADDR_ACK: on scl_fall, release sda_oe. Then:
    - If R/W=0 -> REG.
    - If R/W=1, load tx byte = mem[ptr], drive its MSB in the same cycle -> RDATA.
  - REG: shift 8 bits. On the 8th scl_fall, ptr <= byte mod DEPTH, sda_oe=1 -> REG_ACK. REG_ACK: release on scl_fall -> WDATA.
  - WDATA: shift 8 bits. On the 8th scl_fall:
    - mem[ptr] <= byte; wr_strobe=1 for one clk with wr_addr=ptr and wr_data=byte.
    - ptr <= ptr+1 (wrap); sda_oe=1 -> WDATA_ACK.
    - WDATA_ACK: release on scl_fall -> WDATA.
  - RDATA: sda_oe = ~tx_bit. The next bit is driven on each scl_fall. After the 8th scl_fall, release -> RDATA_ACK.
  - RDATA_ACK: sample the master's bit on scl_rise.
    - ACK (0): ptr <= ptr+1; on scl_fall load mem[ptr+1] and drive its MSB -> RDATA.
    - NACK (1): ptr <= ptr+1 -> IGNORE.
  - IGNORE: sda_oe=0; waits for START or STOP.
- START and STOP handling:
  - Repeated START in any state: sda_oe=0 -> ADDR. ptr is kept, so write-pointer-then-read works.
  - STOP in any state: sda_oe=0 -> IDLE. A partial byte is discarded, with no mem write and no strobe.
- busy: set on address match, cleared on STOP, on START, or on entry to IGNORE after a NACK.
- Reset values:
  - sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0.
  - state=IDLE, ptr=0, bit_cnt=0, every mem byte = INIT_VAL.
  - Synchronizer FFs reset to 1 (idle bus). This prevents false START/STOP after reset.
- Reset mid-transfer releases SDA on the next clk edge. The target then ignores the bus until the next START.
- Minimum supported SCL high/low time is 8 clk_25MHz periods (≤ 1.5 MHz SCL).

Test Plan:
- Write: START, 0xA0, 0x92, 0xAC, STOP -> ACK (SDA low) on all three 9th clocks. wr_strobe pulses once with wr_addr=0x92, wr_data=0xAC. mem[0x92]=0xAC; busy=0 after STOP.
- Random read: after the write above, START, 0xA0, 0x92, repeated START, 0xA1, read 1 byte, master NACK, STOP -> target shifts 0xAC MSB-first and releases SDA in the NACK slot. ptr=0x93.
- Sequential and wrap: write 0x11, 0x22 starting at reg 0xFF -> mem[0xFF]=0x11, mem[0x00]=0x22. Reading 2 bytes from 0xFF with ACK then NACK -> 0x11, 0x22.
- Address mismatch: START, 0xA2 (addr 0x51), STOP -> sda_oe never asserted, busy stays 0, no wr_strobe.
- Abort: STOP after 5 bits of a data byte -> no mem write, no strobe, state IDLE, sda_oe=0. A following full write succeeds.
- Reset mid-read: assert reset while the target drives a 0 data bit -> sda_oe=0 next clk, ptr=0, mem = INIT_VAL. Remaining SCL pulses are ignored until a new START.
